// File: rtl/lc_resp_pkg.sv
// Shared types and constants for the lower-cache responder.
// Constants here describe the default build (64-byte lines, 19-bit paddr, 256 lines).
package lc_resp_pkg;

  localparam int LC_B           = 64;
  localparam int LC_PADDR_BITS  = 19;
  localparam int LC_DEPTH_LINES = 256;
  localparam int OFFSET_BITS    = $clog2(LC_B);
  localparam int INDEX_BITS     = $clog2(LC_DEPTH_LINES);

  typedef logic [8*LC_B-1:0]      line_t;
  typedef logic [LC_PADDR_BITS-1:0] paddr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } lc_resp_state_e;

  function automatic logic [INDEX_BITS-1:0] line_index(input paddr_t paddr);
    return paddr[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
  endfunction

endpackage

// File: rtl/lc_line_store.sv
// Line storage for the lower-cache responder: one synchronous write port and
// one synchronous read port. Contents start at zero and are never reset.
module lc_line_store #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] wr_idx,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_idx] <= wr_data;
    end
    rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/lower_cache_responder.sv
// Single-outstanding line responder for the L1D lower-cache port.
// Optional feature: define LC_RESP_WRITE_ACK_EN to return a response beat for writebacks.
module lower_cache_responder
  import lc_resp_pkg::*;
#(
  parameter int B           = LC_B,
  parameter int PADDR_BITS  = LC_PADDR_BITS,
  parameter int DEPTH_LINES = LC_DEPTH_LINES,
  parameter int LATENCY     = 22
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  cs_N_in,
  input  logic                  lc_valid_in,
  output logic                  lc_ready_out,
  input  logic [PADDR_BITS-1:0] lc_addr_in,
  input  logic [8*B-1:0]        lc_value_in,
  input  logic                  lc_we_in,
  output logic                  lc_valid_out,
  input  logic                  lc_ready_in,
  output logic [PADDR_BITS-1:0] lc_addr_out,
  output logic [8*B-1:0]        lc_value_out
);

  localparam int OFF = $clog2(B);
  localparam int IDX = $clog2(DEPTH_LINES);
  localparam int CW  = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [PADDR_BITS-1:0] ALIGN_MASK = ~(PADDR_BITS'(B - 1));

  lc_resp_state_e        state;
  lc_resp_state_e        next_state;
  logic [CW-1:0]         cnt;
  logic [PADDR_BITS-1:0] req_addr;
  logic [8*B-1:0]        req_data;
  logic                  req_we;
  logic                  accept;
  logic                  done;
  logic                  store_we;
  logic [IDX-1:0]        rd_idx;
  logic [8*B-1:0]        rd_line;

  // The read port follows the incoming address while idle so the line is ready early.
  assign rd_idx = (state == IDLE) ? lc_addr_in[OFF+IDX-1:OFF] : req_addr[OFF+IDX-1:OFF];

  lc_line_store #(
    .WIDTH (8*B),
    .DEPTH (DEPTH_LINES)
  ) u_store (
    .clk     (clk_in),
    .we      (store_we),
    .wr_idx  (req_addr[OFF+IDX-1:OFF]),
    .wr_data (req_data),
    .rd_idx  (rd_idx),
    .rd_data (rd_line)
  );

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    done       = 1'b0;
    store_we   = 1'b0;
    case (state)
      IDLE: begin
        if (lc_valid_in && lc_ready_out) begin
          accept     = 1'b1;
          next_state = BUSY;
        end else begin
          next_state = IDLE;
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          done     = 1'b1;
          store_we = req_we && !rst_in;
`ifdef LC_RESP_WRITE_ACK_EN
          next_state = RESP;
`else
          next_state = req_we ? IDLE : RESP;
`endif
        end else begin
          next_state = BUSY;
        end
      end
      RESP: begin
        if (lc_ready_in) begin
          next_state = IDLE;
        end else begin
          next_state = RESP;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state        <= IDLE;
      cnt          <= '0;
      req_addr     <= '0;
      req_data     <= '0;
      req_we       <= 1'b0;
      lc_ready_out <= 1'b0;
      lc_valid_out <= 1'b0;
      lc_addr_out  <= '0;
      lc_value_out <= '0;
    end else begin
      state        <= next_state;
      lc_ready_out <= (next_state == IDLE) && !cs_N_in;
      lc_valid_out <= (next_state == RESP);
      if (accept) begin
        req_addr <= lc_addr_in;
        req_data <= lc_value_in;
        req_we   <= lc_we_in;
        cnt      <= CW'(LATENCY - 2);
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      // Response payload only changes when a new beat is formed; otherwise it holds.
`ifdef LC_RESP_WRITE_ACK_EN
      if (done) begin
        lc_addr_out  <= req_addr & ALIGN_MASK;
        lc_value_out <= req_we ? req_data : rd_line;
      end
`else
      if (done && !req_we) begin
        lc_addr_out  <= req_addr & ALIGN_MASK;
        lc_value_out <= rd_line;
      end
`endif
    end
  end

endmodule

// File: tb/tb_lower_cache_responder.sv
// Scoreboard bench for lower_cache_responder: random and directed line reads/writes
// checked against an array model of the line store.
module tb_lower_cache_responder;

  localparam int B     = 64;
  localparam int PB    = 19;
  localparam int DEPTH = 256;
  localparam int LAT   = 22;
`ifdef LC_RESP_WRITE_ACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif

  typedef struct {
    logic [PB-1:0]  addr;
    logic [8*B-1:0] data;
    int             due;
    int             hold;
  } exp_t;

  logic           clk_in = 1'b0;
  logic           rst_in;
  logic           cs_N_in;
  logic           lc_valid_in;
  logic           lc_ready_out;
  logic [PB-1:0]  lc_addr_in;
  logic [8*B-1:0] lc_value_in;
  logic           lc_we_in;
  logic           lc_valid_out;
  logic           lc_ready_in;
  logic [PB-1:0]  lc_addr_out;
  logic [8*B-1:0] lc_value_out;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   in_beat = 1'b0;
  exp_t exp_q[$];
  logic [8*B-1:0] model [DEPTH];

  lower_cache_responder dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .cs_N_in      (cs_N_in),
    .lc_valid_in  (lc_valid_in),
    .lc_ready_out (lc_ready_out),
    .lc_addr_in   (lc_addr_in),
    .lc_value_in  (lc_value_in),
    .lc_we_in     (lc_we_in),
    .lc_valid_out (lc_valid_out),
    .lc_ready_in  (lc_ready_in),
    .lc_addr_out  (lc_addr_out),
    .lc_value_out (lc_value_out)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check_eq(input string name, input logic [8*B-1:0] act, input logic [8*B-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic logic [8*B-1:0] rand_line();
    logic [8*B-1:0] l;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic int idx_of(input logic [PB-1:0] a);
    return (int'(a) / B) % DEPTH;
  endfunction

  function automatic logic [PB-1:0] align(input logic [PB-1:0] a);
    return PB'(int'(a) - (int'(a) % B));
  endfunction

  // Issue one request; pushes the expected beat and updates the model at acceptance.
  task automatic do_req(input logic we, input logic [PB-1:0] addr, input logic [8*B-1:0] data,
                        input int hold, input bit commit, input bit cs_pulse, output int acc);
    bit got;
    int waited;
    exp_t e;
    @(posedge clk_in); #1;
    lc_valid_in = 1'b1;
    lc_we_in    = we;
    lc_addr_in  = addr;
    lc_value_in = data;
    got = 1'b0;
    waited = 0;
    while (!got && waited < 300) begin
      @(negedge clk_in);
      if (lc_ready_out) got = 1'b1;
      else waited++;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no ready expected ready within 300 cycles");
      lc_valid_in = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc;
    if (we && commit) model[idx_of(addr)] = data;
    if (!we || (ACK && commit)) begin
      e.addr = align(addr);
      e.data = we ? data : model[idx_of(addr)];
      e.due  = acc + LAT;
      e.hold = hold;
      exp_q.push_back(e);
    end
    @(posedge clk_in); #1;
    lc_valid_in = 1'b0;
    lc_we_in    = 1'b0;
    lc_value_in = rand_line();
    if (cs_pulse) begin
      repeat (2) @(posedge clk_in);
      #1 cs_N_in = 1'b1;
      repeat (3) @(posedge clk_in);
      #1 cs_N_in = 1'b0;
    end
    if (we && commit && !ACK && !cs_pulse) begin
      got = 1'b0;
      waited = 0;
      while (!got && waited < 100) begin
        @(negedge clk_in);
        if (lc_ready_out) got = 1'b1;
        else waited++;
      end
      check_eq("write_ready_return", 512'(cyc), 512'(acc + LAT));
    end
  endtask

  // Chip select high: no acceptance even with a valid request waiting.
  task automatic cs_block();
    @(posedge clk_in); #1 cs_N_in = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    lc_valid_in = 1'b1;
    lc_we_in    = 1'b0;
    lc_addr_in  = PB'($urandom);
    repeat (2) begin
      @(negedge clk_in);
      check_eq("ready_cs_high", 512'(lc_ready_out), 512'(0));
    end
    @(posedge clk_in); #1;
    lc_valid_in = 1'b0;
    cs_N_in     = 1'b0;
  endtask

  // Monitor: pops expectations when a beat appears, controls lc_ready_in, checks hold stability.
  initial begin : monitor
    exp_t cur;
    int   held;
    bit   chk_ready;
    logic cs_low_hs;
    held = 0;
    chk_ready = 1'b0;
    cs_low_hs = 1'b0;
    cur.hold = 0;
    lc_ready_in = 1'b0;
    forever begin
      @(negedge clk_in);
      if (rst_in) begin
        in_beat = 1'b0;
        chk_ready = 1'b0;
        lc_ready_in = 1'b0;
      end else begin
        if (chk_ready) begin
          check_eq("ready_after_handshake", 512'(lc_ready_out), 512'(cs_low_hs));
          chk_ready = 1'b0;
        end
        if (lc_valid_out) begin
          if (!in_beat) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_beat: got valid addr %0h expected no response", lc_addr_out);
              cur.addr = lc_addr_out;
              cur.data = lc_value_out;
              cur.hold = 0;
            end else begin
              cur = exp_q.pop_front();
              check_eq("resp_latency", 512'(cyc), 512'(cur.due));
              check_eq("resp_addr", 512'(lc_addr_out), 512'(cur.addr));
              check_eq("resp_data", lc_value_out, cur.data);
            end
            in_beat = 1'b1;
            held = 0;
          end else begin
            check_eq("hold_addr", 512'(lc_addr_out), 512'(cur.addr));
            check_eq("hold_data", lc_value_out, cur.data);
            check_eq("ready_during_resp", 512'(lc_ready_out), 512'(0));
          end
          if (held >= cur.hold) begin
            lc_ready_in = 1'b1;
            in_beat = 1'b0;
            chk_ready = 1'b1;
            cs_low_hs = !cs_N_in;
          end else begin
            lc_ready_in = 1'b0;
            held++;
          end
        end else begin
          if (in_beat) begin
            checks++;
            errors++;
            $display("FAIL valid_dropped: got valid 0 expected 1 before handshake");
            in_beat = 1'b0;
          end
          lc_ready_in = 1'b0;
        end
      end
    end
  end

  initial begin : stimulus
    int acc;
    int waited;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    rst_in      = 1'b1;
    cs_N_in     = 1'b0;
    lc_valid_in = 1'b0;
    lc_we_in    = 1'b0;
    lc_addr_in  = '0;
    lc_value_in = '0;

    repeat (3) begin
      @(negedge clk_in);
      check_eq("reset_ready", 512'(lc_ready_out), 512'(0));
      check_eq("reset_valid", 512'(lc_valid_out), 512'(0));
      check_eq("reset_addr", 512'(lc_addr_out), 512'(0));
      check_eq("reset_value", lc_value_out, 512'(0));
    end
    @(posedge clk_in); #1 rst_in = 1'b0;
    @(negedge clk_in);
    check_eq("ready_during_release", 512'(lc_ready_out), 512'(0));
    @(negedge clk_in);
    check_eq("ready_after_reset", 512'(lc_ready_out), 512'(1));

    do_req(1'b0, 19'h00040, rand_line(), 0, 1'b1, 1'b0, acc);
    do_req(1'b1, 19'h01FC0, {64{8'hA5}}, 1, 1'b1, 1'b0, acc);
    do_req(1'b0, 19'h01FC7, rand_line(), 0, 1'b1, 1'b0, acc);
    do_req(1'b0, 19'h01FC0, rand_line(), 10, 1'b1, 1'b0, acc);

    do_req(1'b1, 19'h00080, rand_line(), 0, 1'b0, 1'b0, acc);
    repeat (4) @(posedge clk_in);
    #1 rst_in = 1'b1;
    repeat (2) begin
      @(negedge clk_in);
      check_eq("midop_reset_ready", 512'(lc_ready_out), 512'(0));
      check_eq("midop_reset_valid", 512'(lc_valid_out), 512'(0));
    end
    @(posedge clk_in); #1 rst_in = 1'b0;
    do_req(1'b0, 19'h00080, rand_line(), 0, 1'b1, 1'b0, acc);

    do_req(1'b1, 19'h00000, {64{8'h3C}}, 0, 1'b1, 1'b0, acc);
    do_req(1'b0, 19'h04000, rand_line(), 2, 1'b1, 1'b1, acc);

    for (int n = 0; n < 40; n++) begin
      logic [PB-1:0] a;
      logic          w;
      a = PB'(($urandom_range(0, 31) << 14) | ($urandom_range(0, 7) << 6) | $urandom_range(0, 63));
      w = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) cs_block();
      do_req(w, a, rand_line(), $urandom_range(0, 3), 1'b1,
             (!w && $urandom_range(0, 3) == 0), acc);
    end

    waited = 0;
    while ((exp_q.size() != 0 || in_beat) && waited < 400) begin
      @(negedge clk_in);
      waited++;
    end
    if (exp_q.size() != 0 || in_beat) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending beats expected 0", exp_q.size());
    end
    repeat (5) @(posedge clk_in);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lower_cache_responder.md
# lower_cache_responder

Single-outstanding lower-cache responder for the L1 data cache's lower-cache (LC) port. Accepts line-granular read and writeback requests from the L1D on the valid/ready request channel. Services them from an internal line store after a fixed latency and returns read lines on the response channel. Serves as a standalone backing level for L1D bring-up and as the template for the LLC's host-side responder.

## Interface
Parameters:
- B, 64, line size in bytes; must be a power of two.
- PADDR_BITS, 19, physical address width.
- DEPTH_LINES, 256, lines held in the store; must be a power of two.
- LATENCY, 22, cycles from request acceptance to response; must be ≥ 2.

Ports:
- clk_in  in  1  single clock; all logic on the rising edge.
- rst_in  in  1  reset, synchronous, active-high.
- cs_N_in  in  1  chip select, active-low; while high no new request is accepted.
- lc_valid_in  in  1  L1D request valid.
- lc_ready_out  out  1  responder can accept a request.
- lc_addr_in  in  PADDR_BITS  request address; offset bits are ignored.
- lc_value_in  in  8*B  writeback line.
- lc_we_in  in  1  1 = writeback, 0 = line read.
- lc_valid_out  out  1  response valid.
- lc_ready_in  in  1  L1D can accept a response.
- lc_addr_out  out  PADDR_BITS  line-aligned address of the response.
- lc_value_out  out  8*B  read line.

## Operation
- Line index = lc_addr_in[log2(B)+log2(DEPTH_LINES)-1 : log2(B)]. Upper address bits alias.
- The store is zero in simulation at time 0. Reset does not clear it.
- FSM states: IDLE, BUSY, RESP.
- IDLE → BUSY: on lc_valid_in && lc_ready_out. Capture the line-aligned address, the write data and we, and load the counter with LATENCY-2.
- BUSY: decrement the counter each cycle. At counter == 0:
  - read: latch the line into lc_value_out and go to RESP.
  - write: commit the line to the store and go to IDLE.
- RESP: hold lc_valid_out high with lc_addr_out and lc_value_out stable until lc_ready_in is high. Go to IDLE on that edge.
- lc_ready_out is registered. It is 1 only in IDLE, when cs_N_in was low in the previous cycle and not in reset.
- A cs_N_in change has no effect on a request already in flight.
- Response payload is unconstrained while lc_valid_out is 0. The implementation holds the last value.
- A read to a line written earlier returns the written data, because the commit precedes the next accept.

## Timing
- Reset values: lc_ready_out 0, lc_valid_out 0, lc_addr_out 0, lc_value_out 0, state IDLE.
- lc_ready_out rises in the first cycle after rst_in deasserts, provided cs_N_in is low.
- Read accepted in cycle T: lc_valid_out first high in cycle T+LATENCY.
- Write accepted in cycle T: the store is updated at the end of T+LATENCY-1, and lc_ready_out is high again in T+LATENCY.
- Read response held with lc_ready_in low: the response stays valid and stable indefinitely. lc_ready_out becomes high in the cycle after the response handshake.
- Back-to-back throughput: one request per LATENCY+1 cycles, or per LATENCY cycles for writes.
- Reset mid-operation (BUSY or RESP): the in-flight request is dropped and an uncommitted write is lost. Outputs take their reset values on the reset edge.
- lc_valid_in high while lc_ready_out is low: the request is ignored. The initiator must hold the request.

## Configuration
- LC_RESP_WRITE_ACK_EN:
  - Defined: writebacks also enter RESP after commit. lc_valid_out then carries the write address and lc_value_out equals the written line, and the same hold rules apply. Write latency is the same as read latency.
  - Undefined: writebacks are posted and produce no response beat.

## Structure
- Package lc_resp_pkg holds:
  - the state enum lc_resp_state_e;
  - the typedefs line_t (logic [8*B-1:0]) and paddr_t;
  - the function line_index(paddr) and the OFFSET_BITS/INDEX_BITS constants derived from B and DEPTH_LINES.
- Sub-module lc_line_store: DEPTH_LINES × line_t storage with a synchronous write port and a synchronous read port. It is instantiated once. The FSM and counter stay in the top module.

## Test plan
- Reset, then cs_N_in=0 → lc_ready_out=0 during reset, 1 in the first post-reset cycle; lc_valid_out=0 throughout.
- Read 0x00040 after reset (LATENCY=22), lc_ready_in=1 → lc_valid_out high exactly 22 cycles after acceptance, lc_addr_out=0x00040, lc_value_out=0.
- Write line {64{8'hA5}} to 0x01FC0, then read 0x01FC7 → read returns {64{8'hA5}} with lc_addr_out=0x01FC0. Without the macro, no response beat for the write.
- Read with lc_ready_in held low for 10 cycles after valid → valid, address and data stable for all 11 cycles; lc_ready_out stays 0 until the cycle after the handshake.
- Write 0x00080, then assert rst_in 5 cycles after acceptance, then read 0x00080 → returns the pre-write contents (0).
- Aliasing: write {64{8'h3C}} to 0x00000, read 0x04000 (DEPTH_LINES=256) → returns {64{8'h3C}}.
